// File: rtl/rpll_dyn_cfg_ctrl.sv
// rtl/rpll_dyn_cfg_ctrl.sv - run-time preset selector and reset/lock sequencer for a Gowin rPLL
module rpll_dyn_cfg_ctrl #(
    parameter int NUM_CFG = 4,
    parameter logic [18*NUM_CFG-1:0] CFG_TABLE = '0,
    parameter int INIT_CFG = 0,
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_STABLE = 64,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRY = 3,
    localparam int CW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [CW-1:0] req_cfg,
    output logic          req_ready,
    input  logic          pll_lock,
    output logic          pll_reset,
    output logic [5:0]    idsel,
    output logic [5:0]    fbdsel,
    output logic [5:0]    odsel,
    output logic [CW-1:0] cur_cfg,
    output logic          ready,
    output logic          busy,
    output logic          cfg_err,
    output logic          fail
);
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int YW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        S_RST_HOLD,
        S_WAIT_LOCK,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t         state, state_nxt;
    logic           lock_meta, lock_s;
    logic [RW-1:0]  rst_cnt;
    logic [SW-1:0]  stab_cnt;
    logic [TW-1:0]  to_cnt;
    logic [YW-1:0]  retry_cnt;
    logic [17:0]    codes;
    logic           accept, cfg_ok, load_cfg, bad_req, retry_inc;

    function automatic logic [17:0] cfg_entry(input logic [CW-1:0] idx);
        logic [17:0] e;
        e = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (idx == CW'(i)) e = CFG_TABLE[18*i +: 18];
        end
        return e;
    endfunction

    assign cfg_ok = ({1'b0, req_cfg} < (CW+1)'(NUM_CFG));
    assign accept = req_valid && req_ready;

    always_comb begin
        state_nxt = state;
        load_cfg  = 1'b0;
        bad_req   = 1'b0;
        retry_inc = 1'b0;
        case (state)
            S_RST_HOLD: begin
                if (rst_cnt == RW'(RESET_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A completed lock wins over a timeout landing on the same cycle.
                if (lock_s && stab_cnt == SW'(LOCK_STABLE - 1)) begin
                    state_nxt = S_LOCKED;
                end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                    if (retry_cnt == YW'(MAX_RETRY)) begin
                        state_nxt = S_FAIL;
                    end else begin
                        retry_inc = 1'b1;
                        state_nxt = S_RST_HOLD;
                    end
                end
            end
            S_LOCKED: begin
                if (!lock_s) state_nxt = S_WAIT_LOCK;
            end
            default: ;
        endcase
        if (accept) begin
            if (cfg_ok) begin
                load_cfg  = 1'b1;
                state_nxt = S_RST_HOLD;
            end else begin
                bad_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RST_HOLD;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            rst_cnt   <= '0;
            stab_cnt  <= '0;
            to_cnt    <= '0;
            retry_cnt <= '0;
            codes     <= cfg_entry(CW'(INIT_CFG));
            cur_cfg   <= CW'(INIT_CFG);
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            cfg_err   <= bad_req;
            if (load_cfg) begin
                codes   <= cfg_entry(req_cfg);
                cur_cfg <= req_cfg;
            end
            if (state == S_RST_HOLD && state_nxt == S_RST_HOLD) rst_cnt <= rst_cnt + RW'(1);
            else rst_cnt <= '0;
            // Counters restart on every entry to WAIT_LOCK, including relock after lock loss.
            if (state == S_WAIT_LOCK && state_nxt == S_WAIT_LOCK) begin
                to_cnt   <= to_cnt + TW'(1);
                stab_cnt <= lock_s ? stab_cnt + SW'(1) : '0;
            end else begin
                to_cnt   <= '0;
                stab_cnt <= '0;
            end
            if (load_cfg || state_nxt == S_LOCKED) retry_cnt <= '0;
            else if (retry_inc) retry_cnt <= retry_cnt + YW'(1);
        end
    end

    assign {idsel, fbdsel, odsel} = codes;
    assign pll_reset = (state == S_RST_HOLD) || (state == S_FAIL);
    assign ready     = (state == S_LOCKED);
    assign busy      = (state == S_RST_HOLD) || (state == S_WAIT_LOCK);
    assign req_ready = (state == S_LOCKED) || (state == S_FAIL);
    assign fail      = (state == S_FAIL);
endmodule

// File: tb/tb_rpll_dyn_cfg_ctrl.sv
// tb/tb_rpll_dyn_cfg_ctrl.sv - self-checking bench for rpll_dyn_cfg_ctrl
`timescale 1ns/1ps
module tb_rpll_dyn_cfg_ctrl;
    localparam logic [17:0] E0 = {6'h01, 6'h0A, 6'h14};
    localparam logic [17:0] E1 = {6'h02, 6'h0B, 6'h15};
    localparam logic [17:0] E2 = {6'h03, 6'h0C, 6'h16};
    localparam logic [17:0] E3 = {6'h04, 6'h0D, 6'h17};
    localparam int LOCK_DELAY = 10;

    logic clk = 1'b0;
    logic reset, req_valid, req_ready, pll_lock, pll_reset, ready, busy, cfg_err, fail;
    logic [1:0] req_cfg, cur_cfg;
    logic [5:0] idsel, fbdsel, odsel;
    logic d3_valid, d3_req_ready, d3_pll_reset, d3_ready, d3_busy, d3_cfg_err, d3_fail;
    logic [1:0] d3_cfg, d3_cur_cfg;
    logic [5:0] d3_idsel, d3_fbdsel, d3_odsel;

    always #5 clk = ~clk;

    rpll_dyn_cfg_ctrl #(
        .NUM_CFG(4), .CFG_TABLE({E3, E2, E1, E0}), .INIT_CFG(0), .RESET_CYCLES(4),
        .LOCK_STABLE(8), .LOCK_TIMEOUT(100), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_cfg(req_cfg), .req_ready(req_ready),
        .pll_lock(pll_lock), .pll_reset(pll_reset), .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel),
        .cur_cfg(cur_cfg), .ready(ready), .busy(busy), .cfg_err(cfg_err), .fail(fail)
    );

    rpll_dyn_cfg_ctrl #(
        .NUM_CFG(3), .CFG_TABLE({E2, E1, E0}), .INIT_CFG(0), .RESET_CYCLES(4),
        .LOCK_STABLE(8), .LOCK_TIMEOUT(100), .MAX_RETRY(2)
    ) dut3 (
        .clk(clk), .reset(reset), .req_valid(d3_valid), .req_cfg(d3_cfg), .req_ready(d3_req_ready),
        .pll_lock(1'b1), .pll_reset(d3_pll_reset), .idsel(d3_idsel), .fbdsel(d3_fbdsel), .odsel(d3_odsel),
        .cur_cfg(d3_cur_cfg), .ready(d3_ready), .busy(d3_busy), .cfg_err(d3_cfg_err), .fail(d3_fail)
    );

    typedef struct {
        int cfg;
        int lat;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int lo_cnt = 0;
    int glitch_at = -1000;
    bit lock_en = 1'b1;
    bit lock_kill = 1'b0;
    logic ready_d = 1'b0;

    function automatic logic [17:0] ent(input int i);
        case (i)
            0: return E0;
            1: return E1;
            2: return E2;
            default: return E3;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Lock model and ready-rise scoreboard share one process so lo_cnt is coherent.
    always @(negedge clk) begin
        exp_t e;
        if (pll_reset) lo_cnt = 0;
        else lo_cnt++;
        pll_lock = lock_en && !lock_kill && (lo_cnt >= LOCK_DELAY) && (lo_cnt != LOCK_DELAY + glitch_at);
        if (ready && !ready_d) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ready", 32'(ready), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("cur_cfg_at_ready", 32'(cur_cfg), 32'(e.cfg));
                check_eq("codes_at_ready", 32'({idsel, fbdsel, odsel}), 32'(ent(e.cfg)));
                if (e.lat >= 0) check_eq("lock_latency", 32'(lo_cnt), 32'(e.lat));
            end
        end
        ready_d = ready;
    end

    task automatic push_exp(input int cfg, input int lat);
        exp_t e;
        e.cfg = cfg;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic run_len(input logic val, output int len);
        len = 0;
        while (pll_reset === val && len < 300) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(ready), 32'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pll_reset"}, 32'(pll_reset), 32'(1));
        check_eq({tag, "_codes"}, 32'({idsel, fbdsel, odsel}), 32'(E0));
        check_eq({tag, "_cur_cfg"}, 32'(cur_cfg), 32'(0));
        check_eq({tag, "_flags"}, 32'({ready, busy, req_ready, cfg_err, fail}), 32'(5'b01000));
    endtask

    task automatic send_req(input int cfg, input int lat, input bit push);
        @(negedge clk);
        req_valid = 1'b1;
        req_cfg = 2'(cfg);
        check_eq("req_ready", 32'(req_ready), 32'(1));
        if (push) push_exp(cfg, lat);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("codes_after_accept", 32'({idsel, fbdsel, odsel}), 32'(ent(cfg)));
        check_eq("cur_cfg_after_accept", 32'(cur_cfg), 32'(cfg));
        check_eq("flags_after_accept", 32'({pll_reset, ready, busy, fail}), 32'(4'b1010));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int len, n;
        bit saw_rst;
        reset = 1'b1;
        req_valid = 1'b0;
        req_cfg = '0;
        d3_valid = 1'b0;
        d3_cfg = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        // 1: power-up sequence
        push_exp(0, LOCK_DELAY + 2 + 8);
        reset = 1'b0;
        run_len(1'b1, len);
        check_eq("t1_reset_width", 32'(len), 32'(4));
        wait_ready("t1_ready");

        // 2: switch to preset 2
        send_req(2, LOCK_DELAY + 2 + 8, 1'b1);
        run_len(1'b1, len);
        check_eq("t2_reset_width", 32'(len), 32'(4));
        wait_ready("t2_ready");

        // 3: one-cycle lock glitch 3 cycles into the stability window
        glitch_at = 3;
        send_req(1, LOCK_DELAY + 2 + 8 + 3 + 1, 1'b1);
        run_len(1'b1, len);
        check_eq("t3_reset_width", 32'(len), 32'(4));
        wait_ready("t3_ready");
        glitch_at = -1000;

        // 5: invalid preset on the 3-entry instance
        check_eq("t5_d3_ready", 32'(d3_ready), 32'(1));
        @(negedge clk);
        d3_valid = 1'b1;
        d3_cfg = 2'd3;
        check_eq("t5_d3_req_ready", 32'(d3_req_ready), 32'(1));
        @(negedge clk);
        d3_valid = 1'b0;
        check_eq("t5_cfg_err_pulse", 32'(d3_cfg_err), 32'(1));
        check_eq("t5_codes_kept", 32'({d3_idsel, d3_fbdsel, d3_odsel}), 32'(E0));
        check_eq("t5_state_kept", 32'({d3_ready, d3_pll_reset, d3_cur_cfg}), 32'({1'b1, 1'b0, 2'd0}));
        @(negedge clk);
        check_eq("t5_cfg_err_clear", 32'(d3_cfg_err), 32'(0));
        check_eq("t5_main_cfg_err", 32'(cfg_err), 32'(0));

        // 6: lock loss in LOCKED, relock without a PLL reset
        @(posedge clk);
        #2 lock_kill = 1'b1;
        @(negedge clk);
        n = 0;
        saw_rst = 1'b0;
        while (ready === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
            saw_rst |= pll_reset;
        end
        check_eq("t6_drop_latency", 32'(n), 32'(3));
        repeat (20) begin
            @(negedge clk);
            saw_rst |= pll_reset;
        end
        check_eq("t6_busy_during_loss", 32'(busy), 32'(1));
        push_exp(1, -1);
        @(posedge clk);
        #2 lock_kill = 1'b0;
        wait_ready("t6_relock");
        check_eq("t6_no_pll_reset", 32'(saw_rst), 32'(0));

        // 4: lock never comes -> three attempts then FAIL
        lock_en = 1'b0;
        send_req(3, 0, 1'b0);
        for (int a = 0; a < 3; a++) begin
            run_len(1'b1, len);
            check_eq($sformatf("t4_pulse%0d_width", a), 32'(len), 32'(4));
            run_len(1'b0, len);
            check_eq($sformatf("t4_wait%0d_width", a), 32'(len), 32'(100));
        end
        repeat (5) @(negedge clk);
        check_eq("t4_fail_flags", 32'({fail, pll_reset, busy, req_ready, ready}), 32'(5'b11010));
        lock_en = 1'b1;
        send_req(0, LOCK_DELAY + 2 + 8, 1'b1);
        run_len(1'b1, len);
        check_eq("t4_restart_width", 32'(len), 32'(4));
        wait_ready("t4_recover_ready");
        check_eq("t4_fail_cleared", 32'(fail), 32'(0));

        // 6b: reset asserted during WAIT_LOCK
        send_req(3, 0, 1'b0);
        run_len(1'b1, len);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("t6b_reset");
        push_exp(0, LOCK_DELAY + 2 + 8);
        reset = 1'b0;
        run_len(1'b1, len);
        check_eq("t6b_reset_width", 32'(len), 32'(4));
        wait_ready("t6b_ready");

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
